// File: rtl/dmem_arb_pkg.sv
// Shared types and default limits for the DMEM arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXT_BURST = 2'd1,
    RELEASE   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    EXT  = 2'd2
  } owner_e;

  localparam int DEF_MAX_WAIT  = 4;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the DMEM arbiter: core port, external port and DMEM port.
// slave is the arbiter side, master is the surrounding system side.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_ready;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;

  logic          ext_req;
  logic          ext_we;
  logic          ext_lock;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_ready;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    input  mem_rdata,
    output core_ready, core_stall, core_rvalid, core_rdata,
    output ext_ready, ext_rvalid, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    output mem_rdata,
    input  core_ready, core_stall, core_rvalid, core_rdata,
    input  ext_ready, ext_rvalid, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arb_fsm.sv
// Grant decision for the DMEM arbiter: ownership state, ext aging and burst length.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | per-cycle arbitration, core first unless ext has aged out
// EXT_BURST | ext holds the port while it keeps requesting with lock
// RELEASE   | one forced cycle after a max-length burst, core only
module dmem_arb_fsm
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic clk,
  input  logic rst,
  input  logic core_req,
  input  logic ext_req,
  input  logic ext_lock,
  output logic core_gnt,
  output logic ext_gnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e    state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt, beat_inc;
  logic          aged;

  // state, aging and beat registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // grant decode and next-state; grants are suppressed during reset so a
  // request pending across reset never reaches DMEM
  always_comb begin
    core_gnt  = 1'b0;
    ext_gnt   = 1'b0;
    state_nxt = state;
    beat_nxt  = beat_cnt;
    wait_nxt  = wait_cnt;
    beat_inc  = beat_cnt + BW'(1);
    aged      = (wait_cnt >= WW'(MAX_WAIT));

    unique case (state)
      IDLE: begin
        if (core_req && !(ext_req && aged)) begin
          core_gnt = 1'b1;
        end else if (ext_req) begin
          ext_gnt = 1'b1;
          if (ext_lock) begin
            beat_nxt  = BW'(1);
            state_nxt = (MAX_BURST <= 1) ? RELEASE : EXT_BURST;
          end
        end
      end
      EXT_BURST: begin
        if (ext_req) begin
          ext_gnt  = 1'b1;
          beat_nxt = beat_inc;
          if (!ext_lock) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
          end else if (beat_inc == BW'(MAX_BURST)) begin
            state_nxt = RELEASE;
          end
        end else begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end
      end
      RELEASE: begin
        core_gnt  = core_req;
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase

    if (rst) begin
      core_gnt = 1'b0;
      ext_gnt  = 1'b0;
    end

    if (!ext_req || ext_gnt) begin
      wait_nxt = '0;
    end else if (!aged) begin
      wait_nxt = wait_cnt + WW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// DMEM arbiter between the core load/store path and an external port.
// Optional build macro DMEM_ARB_STATS_EN adds conflict / ext-grant counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0] stat_conflicts,
  output logic [31:0] stat_ext_grants,
`endif
  dmem_arbiter_if.slave bus
);

  logic          core_gnt, ext_gnt;
  owner_e        rd_owner;
  logic [DW-1:0] core_rdata_q, ext_rdata_q;
  logic          core_rv, ext_rv;

  dmem_arb_fsm #(
    .MAX_WAIT  (MAX_WAIT),
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .core_req (bus.core_req),
    .ext_req  (bus.ext_req),
    .ext_lock (bus.ext_lock),
    .core_gnt (core_gnt),
    .ext_gnt  (ext_gnt)
  );

  assign bus.core_ready = core_gnt;
  assign bus.ext_ready  = ext_gnt;

  // a core read stalls in its grant cycle; the data lands the cycle after
  assign bus.core_stall = (bus.core_req & ~core_gnt) | (core_gnt & ~bus.core_we);

  // DMEM port mux from the granted requester, zero when idle
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (core_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.core_we;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
    end else if (ext_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.ext_we;
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wdata = bus.ext_wdata;
    end
  end

  // remember who owns the read data arriving next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner <= NONE;
    end else if (core_gnt && !bus.core_we) begin
      rd_owner <= CORE;
    end else if (ext_gnt && !bus.ext_we) begin
      rd_owner <= EXT;
    end else begin
      rd_owner <= NONE;
    end
  end

  assign core_rv = (rd_owner == CORE) & ~rst;
  assign ext_rv  = (rd_owner == EXT) & ~rst;

  // per-port hold registers so each rdata keeps its last delivered word
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      if (core_rv) core_rdata_q <= bus.mem_rdata;
      if (ext_rv)  ext_rdata_q  <= bus.mem_rdata;
    end
  end

  assign bus.core_rvalid = core_rv;
  assign bus.ext_rvalid  = ext_rv;
  assign bus.core_rdata  = core_rv ? bus.mem_rdata : core_rdata_q;
  assign bus.ext_rdata   = ext_rv ? bus.mem_rdata : ext_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  // free-running usage counters, wrap at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflicts  <= '0;
      stat_ext_grants <= '0;
    end else begin
      if (bus.core_req && bus.ext_req) stat_conflicts <= stat_conflicts + 32'd1;
      if (ext_gnt) stat_ext_grants <= stat_ext_grants + 32'd1;
    end
  end
`endif

endmodule
